// File: rtl/ra_lcb_cfg_ctl.sv
// ra_lcb_cfg_ctl
// Configuration sequencer for the SDR local clock buffer strobe generator.
// Owns the LCB cfg register and changes it only while the array is idle, with
// the strobe gated off during the change and for a settle window afterwards.
// Also runs an autonomous tap sweep across [sw_lo, sw_hi]. For each tap it
// collects pass/fail from an external checker and reports the first and last
// passing taps.
//
// State table:
//   IDLE      | waiting for wr_req or sw_start, strobe enabled
//   DRAIN     | strobe gated, waiting for arr_busy to drop (write or restore)
//   APPLY     | load latched cfg, pulse wr_ack (not on a post-sweep restore)
//   SETTLE    | strobe gated for SETTLE cycles, then back to IDLE
//   SW_DRAIN  | sweep: strobe gated, waiting for arr_busy to drop
//   SW_APPLY  | sweep: load current tap into cfg
//   SW_SETTLE | sweep: strobe gated for SETTLE cycles
//   SW_CHECK  | sweep: strobe enabled, waiting for chk_valid
//
// Ports:
//   clk, reset           array clock, async active-low reset
//   arr_busy             array access in flight (cfg must hold)
//   wr_req/wr_cfg/wr_ack cfg write request, value, one-cycle apply pulse
//   sw_start/sw_lo/sw_hi sweep start and tap range
//   chk_valid/chk_pass   checker result for the current tap
//   cfg, strobe_en       cfg bus and strobe enable to the LCBs
//   busy                 high whenever not IDLE
//   sw_done              one-cycle pulse at sweep end
//   sw_found/first/last  held sweep results

`ifndef LCBSDR_CONFIGWIDTH
`define LCBSDR_CONFIGWIDTH 8
`endif

module ra_lcb_cfg_ctl #(
    parameter int              CFGW      = `LCBSDR_CONFIGWIDTH,
    parameter logic [CFGW-1:0] RESET_CFG = '0,
    parameter int              SETTLE    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            arr_busy,
    input  logic            wr_req,
    input  logic [CFGW-1:0] wr_cfg,
    output logic            wr_ack,
    input  logic            sw_start,
    input  logic [CFGW-1:0] sw_lo,
    input  logic [CFGW-1:0] sw_hi,
    input  logic            chk_valid,
    input  logic            chk_pass,
    output logic [CFGW-1:0] cfg,
    output logic            strobe_en,
    output logic            busy,
    output logic            sw_done,
    output logic            sw_found,
    output logic [CFGW-1:0] sw_first,
    output logic [CFGW-1:0] sw_last
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        APPLY,
        SETTLE_ST,
        SW_DRAIN,
        SW_APPLY,
        SW_SETTLE,
        SW_CHECK
    } state_t;

    state_t          state;
    logic [CFGW-1:0] lat_cfg;
    logic [CFGW-1:0] pre_cfg;
    logic [CFGW-1:0] tap;
    logic [CFGW-1:0] hi_eff;
    logic            restore;
    logic [3:0]      cnt;
    logic [CFGW-1:0] final_cfg;

    // Value to settle on when the sweep ends. It accounts for a pass on the
    // very tap being retired in this cycle.
    always_comb begin
        final_cfg = pre_cfg;
        if (sw_found)
            final_cfg = sw_first;
        else if (chk_pass)
            final_cfg = tap;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cfg       <= RESET_CFG;
            strobe_en <= 1'b1;
            wr_ack    <= 1'b0;
            sw_done   <= 1'b0;
            sw_found  <= 1'b0;
            sw_first  <= '0;
            sw_last   <= '0;
            lat_cfg   <= '0;
            pre_cfg   <= '0;
            tap       <= '0;
            hi_eff    <= '0;
            restore   <= 1'b0;
            cnt       <= '0;
        end else begin
            wr_ack  <= 1'b0;
            sw_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        lat_cfg   <= wr_cfg;
                        restore   <= 1'b0;
                        strobe_en <= 1'b0;
                        state     <= DRAIN;
                    end else if (sw_start) begin
                        tap       <= sw_lo;
                        // A reversed range collapses to a single tap at sw_lo.
                        hi_eff    <= (sw_lo > sw_hi) ? sw_lo : sw_hi;
                        pre_cfg   <= cfg;
                        sw_found  <= 1'b0;
                        strobe_en <= 1'b0;
                        state     <= SW_DRAIN;
                    end
                end
                DRAIN: begin
                    if (!arr_busy)
                        state <= APPLY;
                end
                APPLY: begin
                    cfg    <= lat_cfg;
                    wr_ack <= !restore;
                    cnt    <= SETTLE_CNT;
                    state  <= SETTLE_ST;
                end
                SETTLE_ST: begin
                    if (cnt == 4'd1) begin
                        cnt       <= '0;
                        strobe_en <= 1'b1;
                        restore   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SW_DRAIN: begin
                    if (!arr_busy)
                        state <= SW_APPLY;
                end
                SW_APPLY: begin
                    cfg   <= tap;
                    cnt   <= SETTLE_CNT;
                    state <= SW_SETTLE;
                end
                SW_SETTLE: begin
                    if (cnt == 4'd1) begin
                        cnt       <= '0;
                        strobe_en <= 1'b1;
                        state     <= SW_CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SW_CHECK: begin
                    if (chk_valid) begin
                        if (chk_pass) begin
                            if (!sw_found) begin
                                sw_first <= tap;
                                sw_found <= 1'b1;
                            end
                            sw_last <= tap;
                        end
                        strobe_en <= 1'b0;
                        if (tap == hi_eff) begin
                            // The restore reuses the write path but waits for
                            // the array to drain, so cfg never moves under an access.
                            sw_done <= 1'b1;
                            lat_cfg <= final_cfg;
                            restore <= 1'b1;
                            state   <= DRAIN;
                        end else begin
                            tap   <= tap + 1'b1;
                            state <= SW_DRAIN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ra_lcb_cfg_ctl.sv
module tb_ra_lcb_cfg_ctl;

    localparam int CFGW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            arr_busy = 1'b0;
    logic            wr_req = 1'b0;
    logic [CFGW-1:0] wr_cfg = '0;
    logic            wr_ack;
    logic            sw_start = 1'b0;
    logic [CFGW-1:0] sw_lo = '0;
    logic [CFGW-1:0] sw_hi = '0;
    logic            chk_valid = 1'b0;
    logic            chk_pass = 1'b0;
    logic [CFGW-1:0] cfg;
    logic            strobe_en;
    logic            busy;
    logic            sw_done;
    logic            sw_found;
    logic [CFGW-1:0] sw_first;
    logic [CFGW-1:0] sw_last;

    ra_lcb_cfg_ctl #(.CFGW(CFGW), .RESET_CFG(8'h05), .SETTLE(4)) dut (
        .clk(clk), .reset(reset), .arr_busy(arr_busy),
        .wr_req(wr_req), .wr_cfg(wr_cfg), .wr_ack(wr_ack),
        .sw_start(sw_start), .sw_lo(sw_lo), .sw_hi(sw_hi),
        .chk_valid(chk_valid), .chk_pass(chk_pass),
        .cfg(cfg), .strobe_en(strobe_en), .busy(busy), .sw_done(sw_done),
        .sw_found(sw_found), .sw_first(sw_first), .sw_last(sw_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: results of the spec rules, tracked across operations.
    logic [7:0] m_cfg = 8'h05;
    logic [7:0] m_first = 8'h00;
    logic [7:0] m_last = 8'h00;
    logic       m_found = 1'b0;
    bit [255:0] pass_vec;

    int         ack_cnt = 0;
    int         done_cnt = 0;
    int         gate_viol = 0;
    logic       mon_en = 1'b0;
    logic [7:0] prev_cfg = 8'h05;

    always @(negedge clk) begin
        if (wr_ack === 1'b1) ack_cnt++;
        if (sw_done === 1'b1) done_cnt++;
        if (mon_en) begin
            if (cfg !== prev_cfg && strobe_en !== 1'b0) gate_viol++;
        end
        prev_cfg = cfg;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while (busy !== 1'b0 && b < 200) begin
            step();
            b++;
        end
        chk("busy_clear", {31'd0, busy}, 32'd1 - 32'd1);
    endtask

    task automatic do_write(input logic [7:0] v, input int hold);
        int a0;
        int b;
        a0 = ack_cnt;
        wr_cfg = v;
        wr_req = 1'b1;
        arr_busy = (hold > 0);
        repeat (hold) step();
        arr_busy = 1'b0;
        b = 0;
        while (wr_ack !== 1'b1 && b < 50) begin
            step();
            b++;
        end
        chk("wr_ack_seen", {31'd0, wr_ack}, 32'd1);
        wr_req = 1'b0;
        wait_idle();
        m_cfg = v;
        chk("wr_cfg", {24'd0, cfg}, {24'd0, m_cfg});
        chk("wr_ack_pulses", ack_cnt - a0, 32'd1);
        chk("wr_strobe", {31'd0, strobe_en}, 32'd1);
    endtask

    task automatic run_sweep(input logic [7:0] lo, input logic [7:0] hi, input bit rnd_busy);
        int d0;
        int taps;
        int hi_e;
        int b;
        logic [7:0] exp_tap;
        d0 = done_cnt;
        taps = 0;
        hi_e = (lo > hi) ? int'(lo) : int'(hi);
        m_found = 1'b0;
        for (int t = int'(lo); t <= hi_e; t++) begin
            if (pass_vec[t]) begin
                if (!m_found) m_first = 8'(t);
                m_found = 1'b1;
                m_last = 8'(t);
            end
        end
        if (m_found) m_cfg = m_first;
        exp_tap = lo;
        sw_lo = lo;
        sw_hi = hi;
        sw_start = 1'b1;
        step();
        sw_start = 1'b0;
        b = 0;
        while (busy === 1'b1 && b < 3000) begin
            if (busy === 1'b1 && strobe_en === 1'b1) begin
                chk("sw_tap", {24'd0, cfg}, {24'd0, exp_tap});
                taps++;
                repeat ($urandom_range(0, 2)) step();
                chk_valid = 1'b1;
                chk_pass = pass_vec[exp_tap];
                step();
                chk_valid = 1'b0;
                chk_pass = 1'b0;
                exp_tap = exp_tap + 8'd1;
            end else begin
                step();
            end
            if (rnd_busy) arr_busy = ($urandom_range(0, 3) == 0);
            b++;
        end
        arr_busy = 1'b0;
        wait_idle();
        chk("sw_taps", taps, hi_e - int'(lo) + 1);
        chk("sw_done_pulses", done_cnt - d0, 32'd1);
        chk("sw_found", {31'd0, sw_found}, {31'd0, m_found});
        chk("sw_first", {24'd0, sw_first}, {24'd0, m_first});
        chk("sw_last", {24'd0, sw_last}, {24'd0, m_last});
        chk("sw_final_cfg", {24'd0, cfg}, {24'd0, m_cfg});
        chk("sw_strobe", {31'd0, strobe_en}, 32'd1);
    endtask

    initial begin
        int ok_hold;
        int chkwin;
        int d0;
        int b;
        logic [7:0] lo;
        logic [7:0] hi;

        // Reset state
        repeat (3) step();
        chk("rst_cfg", {24'd0, cfg}, 32'h05);
        chk("rst_strobe", {31'd0, strobe_en}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_ack", {31'd0, wr_ack}, 32'd0);
        chk("rst_sw_done", {31'd0, sw_done}, 32'd0);
        chk("rst_sw_found", {31'd0, sw_found}, 32'd0);
        chk("rst_sw_first", {24'd0, sw_first}, 32'd0);
        chk("rst_sw_last", {24'd0, sw_last}, 32'd0);
        reset = 1'b1;
        step();
        prev_cfg = cfg;
        mon_en = 1'b1;

        // Write 3A, arr_busy low: exact latency
        wr_cfg = 8'h3A;
        wr_req = 1'b1;
        step();
        chk("w1_strobe_n", {31'd0, strobe_en}, 32'd0);
        chk("w1_busy_n", {31'd0, busy}, 32'd1);
        chk("w1_cfg_n", {24'd0, cfg}, 32'h05);
        step();
        chk("w1_ack_n1", {31'd0, wr_ack}, 32'd0);
        chk("w1_cfg_n1", {24'd0, cfg}, 32'h05);
        step();
        chk("w1_ack_n2", {31'd0, wr_ack}, 32'd1);
        chk("w1_cfg_n2", {24'd0, cfg}, 32'h3A);
        wr_req = 1'b0;
        step();
        chk("w1_ack_n3", {31'd0, wr_ack}, 32'd0);
        chk("w1_strobe_n3", {31'd0, strobe_en}, 32'd0);
        step();
        step();
        chk("w1_strobe_n5", {31'd0, strobe_en}, 32'd0);
        step();
        chk("w1_strobe_n6", {31'd0, strobe_en}, 32'd1);
        chk("w1_busy_n6", {31'd0, busy}, 32'd0);
        m_cfg = 8'h3A;

        // Write C7 with arr_busy held 6 cycles
        arr_busy = 1'b1;
        wr_cfg = 8'hC7;
        wr_req = 1'b1;
        ok_hold = 1;
        repeat (6) begin
            step();
            if (cfg !== 8'h3A || strobe_en !== 1'b0) ok_hold = 0;
        end
        chk("w2_hold", ok_hold, 32'd1);
        arr_busy = 1'b0;
        step();
        chk("w2_cfg_fall", {24'd0, cfg}, 32'h3A);
        step();
        chk("w2_cfg_upd", {24'd0, cfg}, 32'hC7);
        chk("w2_ack", {31'd0, wr_ack}, 32'd1);
        wr_req = 1'b0;
        wait_idle();
        m_cfg = 8'hC7;

        // Sweep 2..6, pass at 3,4,5
        pass_vec = '0;
        pass_vec[3] = 1'b1;
        pass_vec[4] = 1'b1;
        pass_vec[5] = 1'b1;
        run_sweep(8'd2, 8'd6, 1'b0);
        chk("sw1_final", {24'd0, cfg}, 32'h03);

        // Sweep 0..3 all fail, prior cfg 11
        do_write(8'h11, 0);
        pass_vec = '0;
        run_sweep(8'd0, 8'd3, 1'b0);
        chk("sw2_final", {24'd0, cfg}, 32'h11);
        chk("sw2_found", {31'd0, sw_found}, 32'd0);

        // Reversed range and top-of-range sweeps
        pass_vec = '0;
        pass_vec[9] = 1'b1;
        run_sweep(8'd9, 8'd4, 1'b0);
        pass_vec = '0;
        pass_vec[255] = 1'b1;
        run_sweep(8'd254, 8'd255, 1'b0);

        // wr_req and sw_start together: write wins, no sweep
        d0 = done_cnt;
        chkwin = 0;
        wr_cfg = 8'h5A;
        wr_req = 1'b1;
        sw_start = 1'b1;
        sw_lo = 8'd0;
        sw_hi = 8'd0;
        b = 0;
        while (wr_ack !== 1'b1 && b < 50) begin
            step();
            if (busy === 1'b1 && strobe_en === 1'b1) chkwin++;
            b++;
        end
        chk("both_ack", {31'd0, wr_ack}, 32'd1);
        wr_req = 1'b0;
        sw_start = 1'b0;
        wait_idle();
        m_cfg = 8'h5A;
        chk("both_cfg", {24'd0, cfg}, 32'h5A);
        chk("both_no_check", chkwin, 32'd0);
        chk("both_no_done", done_cnt - d0, 32'd0);

        // Randomized writes and sweeps against the model
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_write(8'($urandom), $urandom_range(0, 3));
            end else begin
                lo = 8'($urandom_range(3, 40));
                if ($urandom_range(0, 4) == 0)
                    hi = lo - 8'($urandom_range(1, 3));
                else
                    hi = lo + 8'($urandom_range(0, 6));
                for (int t = 0; t < 256; t++) pass_vec[t] = ($urandom_range(0, 2) == 0);
                run_sweep(lo, hi, 1'b1);
            end
        end

        chk("gate_violations", gate_viol, 32'd0);

        // Reset during SW_SETTLE
        sw_lo = 8'd8;
        sw_hi = 8'd9;
        sw_start = 1'b1;
        step();
        sw_start = 1'b0;
        b = 0;
        while (cfg !== 8'd8 && b < 40) begin
            step();
            b++;
        end
        chk("mid_cfg_tap", {24'd0, cfg}, 32'd8);
        chk("mid_strobe", {31'd0, strobe_en}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("mrst_cfg", {24'd0, cfg}, 32'h05);
        chk("mrst_strobe", {31'd0, strobe_en}, 32'd1);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_found", {31'd0, sw_found}, 32'd0);
        chk("mrst_first", {24'd0, sw_first}, 32'd0);
        chk("mrst_last", {24'd0, sw_last}, 32'd0);
        step();
        reset = 1'b1;
        step();
        step();
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        chk("post_rst_cfg", {24'd0, cfg}, 32'h05);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ra_lcb_cfg_ctl.md
Name: ra_lcb_cfg_ctl

Overview:
Configuration sequencer for the SDR local clock buffer strobe generator. Owns the LCB delay/width cfg register and applies new settings only while the array is quiescent, with the strobe gated off during the change and a settle window after it. Also runs an autonomous tap sweep that steps cfg across a range, collects pass/fail from an external checker and reports the first passing and last passing settings. Sits between the array control logic / test access and the cfg input of every LCB in a shard.

Parameters:
CFGW, `LCBSDR_CONFIGWIDTH, width of the cfg bus driven to the LCB.
RESET_CFG, 0, cfg value loaded at reset.
SETTLE, 4, cycles the strobe stays gated after cfg changes (legal range 1..15).

Ports:
clk  input  1  array clock.
reset  input  1  asynchronous, active-low reset.
arr_busy  input  1  array access in flight; cfg must not change while high.
wr_req  input  1  request to load wr_cfg.
wr_cfg  input  CFGW  new cfg value.
wr_ack  output  1  one-cycle pulse when wr_cfg is applied.
sw_start  input  1  start sweep (level-sampled in IDLE).
sw_lo  input  CFGW  first tap of sweep.
sw_hi  input  CFGW  last tap of sweep.
chk_valid  input  1  checker result valid for current tap.
chk_pass  input  1  checker result (1 = pass).
cfg  output  CFGW  cfg to LCB.
strobe_en  output  1  strobe enable; ANDed with LCB strobe externally.
busy  output  1  high in any state other than IDLE.
sw_done  output  1  one-cycle pulse at sweep end.
sw_found  output  1  at least one tap passed in last sweep (held).
sw_first  output  CFGW  first passing tap (held).
sw_last  output  CFGW  last passing tap (held).

Behaviour:
- Reset (async, reset=0): state IDLE, cfg=RESET_CFG, strobe_en=1, wr_ack=0, busy=0, sw_done=0, sw_found=0, sw_first=0, sw_last=0, settle counter=0.
- States: IDLE, DRAIN, APPLY, SETTLE, SW_DRAIN, SW_APPLY, SW_SETTLE, SW_CHECK.
- IDLE: wr_req has priority over sw_start when both are high. wr_req -> latch wr_cfg, go DRAIN. sw_start -> latch sw_lo/sw_hi, clear sw_found, set tap=sw_lo, go SW_DRAIN.
- DRAIN/SW_DRAIN: strobe_en=0 from the first cycle. Stay while arr_busy=1; go APPLY/SW_APPLY on the first cycle arr_busy=0.
- APPLY: cfg<=latched value, wr_ack=1 for this cycle only, go SETTLE. SW_APPLY: cfg<=tap, go SW_SETTLE.
- SETTLE/SW_SETTLE: count SETTLE cycles with strobe_en=0, then strobe_en=1. SETTLE returns to IDLE. SW_SETTLE goes to SW_CHECK.
- Write latency with arr_busy=0: wr_req sampled at edge N. wr_ack and the new cfg appear after edge N+2. strobe_en returns to 1 after edge N+2+SETTLE.
- SW_CHECK: strobe_en=1. Wait for chk_valid (no timeout). On pass: if !sw_found then sw_first<=tap, sw_found<=1; sw_last<=tap always.
  - If tap==sw_hi: sw_done=1 for one cycle, cfg<=sw_first if found else restored pre-sweep cfg (applied via the gated SETTLE path), then IDLE.
  - Otherwise tap<=tap+1 and go SW_DRAIN.
- Sweep arithmetic: tap is unsigned CFGW bits. Tap increments never wrap: sweep ends at sw_hi. sw_lo>sw_hi is treated as a single-tap sweep at sw_lo.
- wr_req while busy is ignored (not queued). The requester must hold wr_req until wr_ack.
- chk_valid outside SW_CHECK is ignored.
- busy=1 in all non-IDLE states, including the final restore SETTLE.
- Reset mid-operation: immediate return to reset values. A partial sweep's results are discarded.

Test Plan:
- Reset with CFGW=8, RESET_CFG=8'h05 -> cfg=05, strobe_en=1, busy=0, all sw_* =0.
- wr_req=1, wr_cfg=8'h3A, arr_busy=0, SETTLE=4 -> strobe_en=0 from next cycle; cfg=3A and wr_ack pulse 2 cycles after request; strobe_en=1 4 cycles later; single-cycle wr_ack.
- wr_req with arr_busy held 6 cycles -> cfg unchanged and strobe_en=0 throughout; cfg updates 1 cycle after arr_busy falls.
- Sweep sw_lo=2, sw_hi=6, pass at taps 3,4,5 -> cfg visits 2..6 with a gated settle each; sw_done pulse; sw_found=1, sw_first=3, sw_last=5; final cfg=3.
- Sweep 0..3 all fail, prior cfg=8'h11 -> sw_found=0, final cfg=11, strobe_en=1, busy=0.
- wr_req and sw_start asserted together -> write taken, sweep not started. Reset driven low during SW_SETTLE -> cfg=RESET_CFG, strobe_en=1, state IDLE immediately.
